// File: rtl/dmem_arbiter.sv
// Data memory port arbiter: the pipeline MEM stage has priority; the debug/loader port
// is served in idle MEM cycles, after starvation, or in bounded locked bursts.
module dmem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9,
   parameter int STARVE_MAX = 4,
   parameter int BURST_MAX  = 8,
   parameter int WAIT_W     = $clog2(STARVE_MAX + 1),
   parameter int BURST_W    = $clog2(BURST_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p_rd,
   input  logic                  p_wr,
   input  logic [DM_ADDRESS-1:0] p_addr,
   input  logic [DATA_W-1:0]     p_wdata,
   input  logic [2:0]            p_func3,
   output logic [DATA_W-1:0]     p_rdata,
   output logic                  p_stall,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic                  d_lock,
   input  logic [DM_ADDRESS-1:0] d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [2:0]            d_func3,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  m_rd,
   output logic                  m_wr,
   output logic [DM_ADDRESS-1:0] m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [2:0]            m_func3,
   input  logic [DATA_W-1:0]     m_rdata,
   output logic                  owner,
   output logic                  dbg_state,
   output logic [WAIT_W-1:0]     dbg_wait_cnt,
   output logic [BURST_W-1:0]    dbg_burst_cnt
);

   typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

   state_t               state;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [BURST_W-1:0]   burst_cnt;
   logic [BURST_W-1:0]   burst_nxt;
   logic                 hold_p;
   logic                 p_act;
   logic                 starved;
   logic                 gnt;

   always_comb begin
      p_act     = p_rd | p_wr;
      starved   = (wait_cnt == WAIT_W'(STARVE_MAX));
      if (state == BURST)
         gnt = d_req;
      else
         gnt = d_req & (~p_act | starved) & ~hold_p;
      burst_nxt = burst_cnt + BURST_W'(gnt);
      // A burst keeps the pipeline stalled even in cycles where debug has no request.
      p_stall   = p_act & (gnt | (state == BURST));

      m_addr  = p_addr;
      m_wdata = p_wdata;
      m_func3 = p_func3;
      m_wr    = p_wr;
      m_rd    = p_rd & ~p_wr;
      if (gnt) begin
         m_addr  = d_addr;
         m_wdata = d_wdata;
         m_func3 = d_func3;
         m_wr    = d_we;
         m_rd    = ~d_we;
      end else if (state == BURST) begin
         m_wr = 1'b0;
         m_rd = 1'b0;
      end
   end

   assign d_gnt         = gnt;
   assign owner         = gnt;
   assign p_rdata       = m_rdata;
   assign dbg_state     = state;
   assign dbg_wait_cnt  = wait_cnt;
   assign dbg_burst_cnt = burst_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ARB;
         wait_cnt  <= '0;
         burst_cnt <= '0;
         hold_p    <= 1'b0;
         d_rvalid  <= 1'b0;
         d_rdata   <= '0;
      end else begin
         hold_p   <= 1'b0;
         d_rvalid <= gnt & ~d_we;
         if (gnt && !d_we)
            d_rdata <= m_rdata;
         case (state)
            ARB: begin
               if (gnt) begin
                  wait_cnt <= '0;
                  if (d_lock) begin
                     state     <= BURST;
                     burst_cnt <= BURST_W'(1);
                  end
               end else if (d_req) begin
                  if (!starved)
                     wait_cnt <= wait_cnt + WAIT_W'(1);
               end else begin
                  wait_cnt <= '0;
               end
            end
            BURST: begin
               wait_cnt <= '0;
               // Exit once the grant taken this cycle completes the burst.
               if (!d_lock || burst_nxt == BURST_W'(BURST_MAX)) begin
                  state     <= ARB;
                  hold_p    <= 1'b1;
                  burst_cnt <= '0;
               end else begin
                  burst_cnt <= burst_nxt;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: idle, pipeline, debug read, starvation, burst and
// mid-burst reset scenarios with hand-computed expectations.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        p_rd, p_wr;
   logic [8:0]  p_addr;
   logic [31:0] p_wdata;
   logic [2:0]  p_func3;
   logic [31:0] p_rdata;
   logic        p_stall;
   logic        d_req, d_we, d_lock;
   logic [8:0]  d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_func3;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_rd, m_wr;
   logic [8:0]  m_addr;
   logic [31:0] m_wdata;
   logic [2:0]  m_func3;
   logic [31:0] m_rdata;
   logic        owner;
   logic        dbg_state;
   logic [2:0]  dbg_wait_cnt;
   logic [3:0]  dbg_burst_cnt;

   int checks = 0;
   int errors = 0;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_func3(p_func3),
      .p_rdata(p_rdata), .p_stall(p_stall),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_func3(d_func3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_func3(m_func3),
      .m_rdata(m_rdata), .owner(owner),
      .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt), .dbg_burst_cnt(dbg_burst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      p_rd = 0; p_wr = 0; p_addr = 9'h0; p_wdata = 32'h0; p_func3 = 3'b010;
      d_req = 0; d_we = 0; d_lock = 0; d_addr = 9'h0; d_wdata = 32'h0; d_func3 = 3'b010;
      m_rdata = 32'h0;
      tick();
      chk("rst_state", 32'(dbg_state), 0);
      chk("rst_wait", 32'(dbg_wait_cnt), 0);
      chk("rst_burst", 32'(dbg_burst_cnt), 0);
      chk("rst_rvalid", 32'(d_rvalid), 0);
      chk("rst_rdata", d_rdata, 0);
      chk("idle_m_rd", 32'(m_rd), 0);
      chk("idle_m_wr", 32'(m_wr), 0);
      reset = 1'b1;
      tick();

      // Pipeline read with no debug traffic
      p_rd = 1; p_addr = 9'h010; m_rdata = 32'hDEADBEEF;
      #1;
      chk("p_rd_stall", 32'(p_stall), 0);
      chk("p_rd_owner", 32'(owner), 0);
      chk("p_rd_m_rd", 32'(m_rd), 1);
      chk("p_rd_m_addr", 32'(m_addr), 32'h010);
      chk("p_rd_rdata", p_rdata, 32'hDEADBEEF);
      tick();

      // Debug read in an idle MEM cycle
      p_rd = 0; d_req = 1; d_we = 0; d_addr = 9'h020; m_rdata = 32'h12345678;
      #1;
      chk("dbg_rd_gnt", 32'(d_gnt), 1);
      chk("dbg_rd_m_addr", 32'(m_addr), 32'h020);
      chk("dbg_rd_m_rd", 32'(m_rd), 1);
      tick();
      d_req = 0; m_rdata = 32'h0;
      chk("dbg_rvalid1", 32'(d_rvalid), 1);
      chk("dbg_rdata1", d_rdata, 32'h12345678);
      tick();
      chk("dbg_rvalid2", 32'(d_rvalid), 0);
      chk("dbg_rdata_hold", d_rdata, 32'h12345678);

      // Read and write together: write wins
      p_rd = 1; p_wr = 1;
      #1;
      chk("rw_m_wr", 32'(m_wr), 1);
      chk("rw_m_rd", 32'(m_rd), 0);
      chk("rw_stall", 32'(p_stall), 0);
      tick();

      // Starvation guard: 4 denials, then a forced grant
      p_wr = 0; p_rd = 1; d_req = 1; d_we = 1; d_lock = 0; d_addr = 9'h030;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("starve_deny%0d", i), 32'(d_gnt), 0);
         chk($sformatf("starve_nostall%0d", i), 32'(p_stall), 0);
         tick();
      end
      chk("starve_wait_sat", 32'(dbg_wait_cnt), 4);
      chk("starve_gnt", 32'(d_gnt), 1);
      chk("starve_stall", 32'(p_stall), 1);
      chk("starve_owner", 32'(owner), 1);
      chk("starve_m_wr", 32'(m_wr), 1);
      chk("starve_m_addr", 32'(m_addr), 32'h030);
      tick();
      chk("starve_wait_clr", 32'(dbg_wait_cnt), 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("starve_redeny%0d", i), 32'(d_gnt), 0);
         tick();
      end
      d_req = 0;
      tick();

      // Locked burst against a continuous pipeline write
      p_rd = 0; p_wr = 1; p_addr = 9'h044; d_req = 1; d_we = 1; d_lock = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("burst_pre_deny%0d", i), 32'(d_gnt), 0);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("burst_gnt%0d", i), 32'(d_gnt), 1);
         chk($sformatf("burst_stall%0d", i), 32'(p_stall), 1);
         tick();
      end
      chk("hold_state", 32'(dbg_state), 0);
      chk("hold_owner", 32'(owner), 0);
      chk("hold_stall", 32'(p_stall), 0);
      chk("hold_m_wr", 32'(m_wr), 1);
      chk("hold_m_addr", 32'(m_addr), 32'h044);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("post_deny%0d", i), 32'(d_gnt), 0);
         tick();
      end
      chk("post_regrant", 32'(d_gnt), 1);
      tick();
      chk("reburst_state", 32'(dbg_state), 1);
      d_req = 0;
      #1;
      chk("burst_idle_gnt", 32'(d_gnt), 0);
      chk("burst_idle_stall", 32'(p_stall), 1);
      chk("burst_idle_m_wr", 32'(m_wr), 0);
      tick();
      chk("burst_idle_state", 32'(dbg_state), 1);
      d_lock = 0;
      tick();
      chk("unlock_exit", 32'(dbg_state), 0);
      chk("unlock_hold_stall", 32'(p_stall), 0);
      p_wr = 0;
      tick();

      // Reset in the middle of a read burst
      d_req = 1; d_we = 0; d_lock = 1; d_addr = 9'h050; m_rdata = 32'hAAAA5555;
      tick();
      tick();
      tick();
      chk("mid_burst_cnt", 32'(dbg_burst_cnt), 3);
      chk("mid_state", 32'(dbg_state), 1);
      chk("mid_rvalid", 32'(d_rvalid), 1);
      chk("mid_gnt", 32'(d_gnt), 1);
      #1 reset = 1'b0;
      #1;
      chk("rst_mid_rvalid", 32'(d_rvalid), 0);
      chk("rst_mid_state", 32'(dbg_state), 0);
      chk("rst_mid_burst", 32'(dbg_burst_cnt), 0);
      p_rd = 1; p_addr = 9'h060;
      #1 reset = 1'b1;
      #1;
      chk("rel_gnt", 32'(d_gnt), 0);
      chk("rel_owner", 32'(owner), 0);
      chk("rel_stall", 32'(p_stall), 0);
      chk("rel_m_rd", 32'(m_rd), 1);
      chk("rel_m_addr", 32'(m_addr), 32'h060);
      tick();
      chk("rel_rvalid", 32'(d_rvalid), 0);
      chk("rel_state", 32'(dbg_state), 0);
      chk("rel_wait", 32'(dbg_wait_cnt), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
